rgmii_tx_framer: RTL and testbench

RGMII_TX_FRAMER -- requirements
Module: rgmii_tx_framer

---
 rtl/rgmii_tx_framer_if.sv | 15 +
 rtl/rgmii_tx_framer.sv | 171 +++++++++++++++++
 tb/tb_rgmii_tx_framer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgmii_tx_framer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rgmii_tx_framer_if : byte-stream handshake feeding the RGMII TX framer     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface rgmii_tx_framer_if;
  logic [7:0] DATA_IN;
  logic       VALID;
  logic       LAST;
  logic       READY;

  modport master (output DATA_IN, output VALID, output LAST, input READY);
  modport slave  (input DATA_IN, input VALID, input LAST, output READY);
endinterface
`default_nettype wire

// File: rtl/rgmii_tx_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rgmii_tx_framer : byte stream to RGMII DDR nibbles with preamble/IFG      |
// | Optional: RGMII_TX_PREAMBLE_EN inserts 7x0x55 + 0xD5 before the payload.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rgmii_tx_framer (
  input  logic             TXC,
  input  logic             RST,
  input  logic [1:0]       SPEED,
  rgmii_tx_framer_if.slave s_bus,
  output logic [3:0]       TXD_H,
  output logic [3:0]       TXD_L,
  output logic             CTL_H,
  output logic             CTL_L,
  output logic             UNDERRUN,
  output logic             BUSY
);

`ifdef RGMII_TX_PREAMBLE_EN
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_PAYLOAD  = 2'd2,
    S_IFG      = 2'd3
  } state_t;

  localparam logic [7:0] c_PRE_BYTE = 8'h55;
  localparam logic [7:0] c_SFD_BYTE = 8'hD5;
  localparam logic [2:0] c_PRE_LAST = 3'd7;
`else
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PAYLOAD  = 2'd2,
    S_IFG      = 2'd3
  } state_t;
`endif

  localparam logic [3:0] c_IFG_LAST = 4'd11;

  state_t     r_state;
  logic       r_gig;
  logic       r_phase;
  logic       r_err;
  logic       r_last;
  logic [7:0] r_byte;
  logic [3:0] r_ifg_cnt;
`ifdef RGMII_TX_PREAMBLE_EN
  logic [2:0] r_pre_cnt;
  logic [7:0] w_pre_byte;
  assign w_pre_byte = (r_pre_cnt == c_PRE_LAST) ? c_SFD_BYTE : c_PRE_BYTE;
`endif

  logic w_slot_start;
  logic w_slot_end;
  logic w_speed_unused;

  // A byte slot is one cycle at gigabit, two (phase 0 then 1) in nibble mode.
  assign w_slot_start   = r_gig | ~r_phase;
  assign w_slot_end     = r_gig | r_phase;
  assign w_speed_unused = SPEED[0];

  assign s_bus.READY = (r_state == S_PAYLOAD) && w_slot_start;
  assign BUSY        = (r_state != S_IDLE);

  // Returns {TXD_L, TXD_H} for one cycle of a byte slot.
  function automatic logic [7:0] lanes(input logic [7:0] b, input logic gig, input logic ph);
    if (gig)     lanes = b;
    else if (ph) lanes = {b[7:4], b[7:4]};
    else         lanes = {b[3:0], b[3:0]};
  endfunction

  always_ff @(posedge TXC or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_gig     <= 1'b0;
      r_phase   <= 1'b0;
      r_err     <= 1'b0;
      r_last    <= 1'b0;
      r_byte    <= 8'h00;
      r_ifg_cnt <= 4'd0;
`ifdef RGMII_TX_PREAMBLE_EN
      r_pre_cnt <= 3'd0;
`endif
      TXD_H     <= 4'h0;
      TXD_L     <= 4'h0;
      CTL_H     <= 1'b0;
      CTL_L     <= 1'b0;
      UNDERRUN  <= 1'b0;
    end else begin
      TXD_H    <= 4'h0;
      TXD_L    <= 4'h0;
      CTL_H    <= 1'b0;
      CTL_L    <= 1'b0;
      UNDERRUN <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_phase <= 1'b0;
          if (s_bus.VALID) begin
            r_gig <= SPEED[1];
`ifdef RGMII_TX_PREAMBLE_EN
            r_pre_cnt <= 3'd0;
            r_state   <= S_PREAMBLE;
`else
            r_state   <= S_PAYLOAD;
`endif
          end
        end
`ifdef RGMII_TX_PREAMBLE_EN
        S_PREAMBLE: begin
          {TXD_L, TXD_H} <= lanes(w_pre_byte, r_gig, r_phase);
          CTL_H   <= 1'b1;
          CTL_L   <= 1'b1;
          r_phase <= ~r_gig & ~r_phase;
          if (w_slot_end) begin
            if (r_pre_cnt == c_PRE_LAST) begin
              r_pre_cnt <= 3'd0;
              r_state   <= S_PAYLOAD;
            end else begin
              r_pre_cnt <= r_pre_cnt + 3'd1;
            end
          end
        end
`endif
        S_PAYLOAD: begin
          CTL_H   <= 1'b1;
          r_phase <= ~r_gig & ~r_phase;
          if (w_slot_start) begin
            r_err  <= ~s_bus.VALID;
            r_last <= s_bus.VALID & s_bus.LAST;
            if (s_bus.VALID) begin
              r_byte         <= s_bus.DATA_IN;
              {TXD_L, TXD_H} <= lanes(s_bus.DATA_IN, r_gig, 1'b0);
              CTL_L          <= 1'b1;
            end else begin
              // Starved slot: TX_EN=1 with TX_ER=1 and zero data.
              UNDERRUN <= 1'b1;
            end
            if (r_gig && s_bus.VALID && s_bus.LAST) begin
              r_ifg_cnt <= 4'd0;
              r_state   <= S_IFG;
            end
          end else begin
            if (!r_err) begin
              {TXD_L, TXD_H} <= lanes(r_byte, 1'b0, 1'b1);
              CTL_L          <= 1'b1;
            end
            if (r_last) begin
              r_ifg_cnt <= 4'd0;
              r_state   <= S_IFG;
            end
          end
        end
        S_IFG: begin
          r_phase <= ~r_gig & ~r_phase;
          if (w_slot_end) begin
            if (r_ifg_cnt == c_IFG_LAST) begin
              r_ifg_cnt <= 4'd0;
              r_state   <= S_IDLE;
            end else begin
              r_ifg_cnt <= r_ifg_cnt + 4'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rgmii_tx_framer.sv
`default_nettype none
// Randomized bench for rgmii_tx_framer: symbol stream predicted per frame from
// the framing rules (preamble, byte slots, error slots, inter-frame gap).
module tb_rgmii_tx_framer;
  logic       TXC = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] SPEED = 2'b10;
  logic [3:0] TXD_H;
  logic [3:0] TXD_L;
  logic       CTL_H;
  logic       CTL_L;
  logic       UNDERRUN;
  logic       BUSY;

  int n_checks = 0;
  int n_fail   = 0;
  int plan[$];   // payload plan: 0..255 = byte, -1 = starved slot

`ifdef RGMII_TX_PREAMBLE_EN
  localparam int PRE_BYTES = 8;
`else
  localparam int PRE_BYTES = 0;
`endif

  rgmii_tx_framer_if bus ();

  rgmii_tx_framer dut (
    .TXC      (TXC),
    .RST      (RST),
    .SPEED    (SPEED),
    .s_bus    (bus),
    .TXD_H    (TXD_H),
    .TXD_L    (TXD_L),
    .CTL_H    (CTL_H),
    .CTL_L    (CTL_L),
    .UNDERRUN (UNDERRUN),
    .BUSY     (BUSY)
  );

  always #4 TXC = ~TXC;

  task automatic step();
    @(posedge TXC);
    #1;
  endtask

  task automatic drive_random();
    bus.VALID   = 1'($urandom_range(0, 1));
    bus.DATA_IN = 8'($urandom);
    bus.LAST    = 1'($urandom_range(0, 1));
  endtask

  // Outputs observed per cycle: {TXD_H, TXD_L, CTL_H, CTL_L, UNDERRUN, BUSY, READY}
  task automatic idle_cycles(input int n);
    logic [12:0] got;
    for (int c = 0; c < n; c++) begin
      bus.VALID   = 1'b0;
      bus.DATA_IN = 8'($urandom);
      bus.LAST    = 1'($urandom_range(0, 1));
      SPEED       = 2'($urandom_range(0, 3));
      @(negedge TXC);
      got = {TXD_H, TXD_L, CTL_H, CTL_L, UNDERRUN, BUSY, bus.READY};
      n_checks++;
      if (got !== 13'h0) begin
        n_fail++;
        $display("FAIL idle c=%0d got=%h exp=%h", c, got, 13'h0);
      end
      step();
    end
  endtask

  // Sends the frame in plan; entered and left in an IDLE cycle, just after a
  // rising edge. abort_c >= 0 asserts reset mid-cycle at that frame cycle.
  task automatic run_frame(input bit gig, input int abort_c, input string tag);
    int k, n, pre, c_last, c_end, j, i, ph;
    logic [7:0]  eb;
    logic [3:0]  eh, el;
    logic        ech, ecl, eund, erdy;
    logic [12:0] got, exp_v;
    k      = gig ? 1 : 2;
    n      = plan.size();
    pre    = PRE_BYTES * k;
    c_last = pre + n * k;
    c_end  = c_last + 12 * k;

    SPEED       = gig ? (2'b10 | 2'($urandom_range(0, 1))) : 2'($urandom_range(0, 1));
    bus.VALID   = 1'b1;
    bus.DATA_IN = 8'(plan[0]);
    bus.LAST    = (n == 1);
    @(negedge TXC);
    got = {TXD_H, TXD_L, CTL_H, CTL_L, UNDERRUN, BUSY, bus.READY};
    n_checks++;
    if (got !== 13'h0) begin
      n_fail++;
      $display("FAIL %s_start got=%h exp=%h", tag, got, 13'h0);
    end
    step();

    for (int c = 0; c < c_end; c++) begin
      SPEED = 2'($urandom_range(0, 3));
      if (c >= pre && c < c_last && (c - pre) % k == 0) begin
        i = (c - pre) / k;
        if (plan[i] < 0) begin
          bus.VALID   = 1'b0;
          bus.DATA_IN = 8'($urandom);
          bus.LAST    = 1'($urandom_range(0, 1));
        end else begin
          bus.VALID   = 1'b1;
          bus.DATA_IN = 8'(plan[i]);
          bus.LAST    = (i == n - 1);
        end
      end else begin
        drive_random();
      end

      eb = 8'h00; ech = 1'b0; ecl = 1'b0; eund = 1'b0; ph = 0;
      if (c >= 1 && c <= pre) begin
        j   = c - 1;
        ph  = j % k;
        eb  = (j / k == 7) ? 8'hD5 : 8'h55;
        ech = 1'b1;
        ecl = 1'b1;
      end else if (c > pre && c <= c_last) begin
        j   = c - 1 - pre;
        i   = j / k;
        ph  = j % k;
        ech = 1'b1;
        if (plan[i] < 0) begin
          eund = (ph == 0);
        end else begin
          eb  = 8'(plan[i]);
          ecl = 1'b1;
        end
      end
      if (k == 1) begin
        eh = eb[3:0]; el = eb[7:4];
      end else if (ph == 1) begin
        eh = eb[7:4]; el = eb[7:4];
      end else begin
        eh = eb[3:0]; el = eb[3:0];
      end
      erdy  = (c >= pre && c < c_last && (c - pre) % k == 0);
      exp_v = {eh, el, ech, ecl, eund, 1'b1, erdy};

      @(negedge TXC);
      got = {TXD_H, TXD_L, CTL_H, CTL_L, UNDERRUN, BUSY, bus.READY};
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL %s c=%0d got=%h exp=%h", tag, c, got, exp_v);
      end

      if (c == abort_c) begin
        #2 RST = 1'b1;
        #1;
        got = {TXD_H, TXD_L, CTL_H, CTL_L, UNDERRUN, BUSY, bus.READY};
        n_checks++;
        if (got !== 13'h0) begin
          n_fail++;
          $display("FAIL %s_async_rst got=%h exp=%h", tag, got, 13'h0);
        end
        step();
        RST = 1'b0;
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    logic [12:0] got;
    bus.VALID   = 1'b1;
    bus.DATA_IN = 8'hFF;
    bus.LAST    = 1'b0;
    SPEED       = 2'b11;
    for (int c = 0; c < 3; c++) begin
      @(negedge TXC);
      got = {TXD_H, TXD_L, CTL_H, CTL_L, UNDERRUN, BUSY, bus.READY};
      n_checks++;
      if (got !== 13'h0) begin
        n_fail++;
        $display("FAIL reset_hold c=%0d got=%h exp=%h", c, got, 13'h0);
      end
    end
    step();
    RST       = 1'b0;
    bus.VALID = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_gig_frame();
    plan = '{8'h11, 8'h22, 8'h33};
    run_frame(1'b1, -1, "gig3");
    idle_cycles(2);
  endtask

  task automatic test_nibble_single();
    plan = '{8'hA7};
    run_frame(1'b0, -1, "nib_a7");
    idle_cycles(1);
  endtask

  task automatic test_single_55();
    plan = '{8'h55};
    run_frame(1'b1, -1, "gig_55");
    idle_cycles(1);
  endtask

  task automatic test_underrun();
    plan = '{8'h11, -1, -1, 8'h22, 8'h33};
    run_frame(1'b1, -1, "gig_under");
    idle_cycles(1);
    plan = '{8'h5A, -1, 8'hC3};
    run_frame(1'b0, -1, "nib_under");
    idle_cycles(1);
  endtask

  task automatic test_reset_midframe();
    plan = '{8'h12, 8'h34, 8'h56, 8'h78};
    run_frame(1'b1, PRE_BYTES + 2, "mid_rst");
    plan = '{8'h9E, 8'h4B};
    run_frame(1'b1, -1, "after_rst");
    idle_cycles(1);
  endtask

  task automatic test_back_to_back();
    plan = '{8'hDE, 8'hAD};
    run_frame(1'b1, -1, "b2b_0");
    plan = '{8'hBE, 8'hEF, 8'h01};
    run_frame(1'b0, -1, "b2b_1");
    plan = '{8'h3C};
    run_frame(1'b1, -1, "b2b_2");
    idle_cycles(1);
  endtask

  task automatic test_random();
    int nb;
    for (int f = 0; f < 20; f++) begin
      plan.delete();
      plan.push_back(int'($urandom_range(0, 255)));
      nb = int'($urandom_range(0, 15));
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 4) == 0) plan.push_back(-1);
        plan.push_back(int'($urandom_range(0, 255)));
      end
      run_frame(1'($urandom_range(0, 1)), -1, "rand");
      if ($urandom_range(0, 1) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end
    idle_cycles(1);
  endtask

  initial begin
    bus.VALID   = 1'b0;
    bus.DATA_IN = 8'h00;
    bus.LAST    = 1'b0;
    test_reset();
    test_gig_frame();
    test_nibble_single();
    test_single_55();
    test_underrun();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
